// File: rtl/apb2reg_bridge.sv
// apb2reg_bridge: APB slave to simple register-bus bridge with address checking, read timeout and error counting.
module apb2reg_bridge #(
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT     = ADDR_WIDTH'('h20),
  parameter int                    TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  chip_select,
  output logic                  write_en,
  output logic                  read_en,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  data_valid,
  output logic [7:0]            err_cnt
);
  typedef enum logic [2:0] {IDLE, WR, RD, ERR, DONE} state_t;
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT_CYCLES - 1);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, prdata_q, prdata_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic                  pready_q, pready_d, pslverr_q, pslverr_d;
  logic                  cs_q, cs_d, we_q, we_d, re_q, re_d;
  logic                  bad_addr, rd_ok, respond;
  assign bad_addr = (paddr >= ADDR_LIMIT) || (paddr[1:0] != 2'b00);
  assign rd_ok    = (state_q == RD) && data_valid;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (psel) begin
        addr_d  = paddr;
        wdata_d = pwdata;
        cnt_d   = 4'd0;
        state_d = bad_addr ? ERR : pwrite ? WR : RD;
      end
      WR:   state_d = DONE;
      RD:   if (data_valid) state_d = DONE;
            else begin
              cnt_d   = cnt_q + 4'd1;
              state_d = (cnt_q == TO_LAST) ? DONE : RD;
            end
      ERR:  state_d = DONE;
      default: state_d = IDLE;
    endcase
    // Response is decided on entry to DONE; an abandoned transfer never raises pready.
    respond   = (state_d == DONE) && (state_q != DONE) && psel && penable;
    pready_d  = respond;
    pslverr_d = respond && !rd_ok && (state_q != WR);
    prdata_d  = (respond && rd_ok) ? read_data : '0;
    cs_d      = (state_d == WR) || (state_d == RD);
    we_d      = state_d == WR;
    re_d      = state_d == RD;
    err_cnt_d = (pready_q && pslverr_q && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      cs_q      <= cs_d;
      we_q      <= we_d;
      re_q      <= re_d;
    end
  end
  assign pready      = pready_q;
  assign prdata      = prdata_q;
  assign pslverr     = pslverr_q;
  assign addr        = addr_q;
  assign chip_select = cs_q;
  assign write_en    = we_q;
  assign read_en     = re_q;
  assign write_data  = wdata_q;
  assign err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_apb2reg_bridge.sv
// tb_apb2reg_bridge: scoreboard-driven bench for the APB to register-bus bridge.
module tb_apb2reg_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic        pready, pslverr, chip_select, write_en, read_en, data_valid;
  logic [31:0] prdata, write_data, read_data;
  logic [7:0]  addr, err_cnt;
  logic        dv_en = 1'b1;
  logic [31:0] mem [8];
  int          checks = 0, errors = 0, cyc = 0;
  typedef struct {logic err; logic [31:0] data;} resp_t;
  resp_t sb[$];

  apb2reg_bridge dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .addr(addr), .chip_select(chip_select), .write_en(write_en), .read_en(read_en),
    .write_data(write_data), .read_data(read_data), .data_valid(data_valid), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Zero-wait register file model; data_valid can be withheld to force a timeout.
  always @(posedge clk) if (write_en) mem[addr[4:2]] <= write_data;
  assign data_valid = dv_en & read_en;
  assign read_data  = mem[addr[4:2]];

  task automatic apb_xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                          output logic got, output logic [31:0] rd, output logic err,
                          output int cyc_n, output int n_we, output int n_re, output int n_both,
                          output logic [7:0] s_addr, output logic [31:0] s_wd);
    n_we = 0; n_re = 0; n_both = 0; s_addr = '0; s_wd = '0;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1; cyc_n = 1;
    while (!pready && cyc_n < 40) begin
      if (write_en) begin n_we++; s_addr = addr; s_wd = write_data; end
      if (read_en) begin n_re++; s_addr = addr; end
      if (write_en && read_en) n_both++;
      @(posedge clk); #1;
      cyc_n++;
    end
    got = pready; rd = prdata; err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pready, pslverr, chip_select, write_en, read_en} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {pready, pslverr, chip_select, write_en, read_en});
    end
    checks++;
    if ({prdata, write_data, addr, err_cnt} !== 80'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {prdata, write_data, addr, err_cnt});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (pready !== 1'b0) begin errors++; $display("FAIL reset_idle_pready: got %b expected 0", pready); end
  endtask

  task automatic test_write();
    logic got, err; logic [31:0] rd, wd; logic [7:0] sa; int c, nw, nr, nb; resp_t e;
    sb.push_back('{err: 1'b0, data: 32'h0});
    apb_xfer(1'b1, 8'h04, 32'hDEADBEEF, got, rd, err, c, nw, nr, nb, sa, wd);
    e = sb.pop_front();
    checks++; if (!got || c != 2) begin errors++; $display("FAIL wr_latency: got ready=%b cycle=%0d expected 1/2", got, c); end
    checks++; if (nw != 1 || nr != 0) begin errors++; $display("FAIL wr_strobes: got we=%0d re=%0d expected 1/0", nw, nr); end
    checks++; if (sa !== 8'h04 || wd !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_bus: got %h/%h expected 04/deadbeef", sa, wd); end
    checks++; if (err !== e.err || rd !== e.data) begin errors++; $display("FAIL wr_resp: got %b/%h expected %b/%h", err, rd, e.err, e.data); end
  endtask

  task automatic test_read();
    logic got, err; logic [31:0] rd, wd; logic [7:0] sa; int c, nw, nr, nb; resp_t e;
    dv_en = 1'b1;
    sb.push_back('{err: 1'b0, data: 32'h1});
    apb_xfer(1'b0, 8'h08, 32'h0, got, rd, err, c, nw, nr, nb, sa, wd);
    e = sb.pop_front();
    checks++; if (!got || c != 2) begin errors++; $display("FAIL rd_latency: got ready=%b cycle=%0d expected 1/2", got, c); end
    checks++; if (nr != 1 || nw != 0 || sa !== 8'h08) begin errors++; $display("FAIL rd_strobes: got re=%0d we=%0d addr=%h expected 1/0/08", nr, nw, sa); end
    checks++; if (err !== e.err || rd !== e.data) begin errors++; $display("FAIL rd_resp: got %b/%h expected %b/%h", err, rd, e.err, e.data); end
    checks++; if (prdata !== 32'h0 || pslverr !== 1'b0) begin errors++; $display("FAIL rd_idle_zero: got %h/%b expected 0/0", prdata, pslverr); end
  endtask

  task automatic test_timeout();
    logic got, err; logic [31:0] rd, wd; logic [7:0] sa; int c, nw, nr, nb; resp_t e;
    dv_en = 1'b0;
    sb.push_back('{err: 1'b1, data: 32'h0});
    apb_xfer(1'b0, 8'h0C, 32'h0, got, rd, err, c, nw, nr, nb, sa, wd);
    e = sb.pop_front();
    dv_en = 1'b1;
    checks++; if (nr != 15 || !got || c != 16) begin errors++; $display("FAIL to_length: got re=%0d ready=%b cycle=%0d expected 15/1/16", nr, got, c); end
    checks++; if (err !== e.err || rd !== e.data) begin errors++; $display("FAIL to_resp: got %b/%h expected %b/%h", err, rd, e.err, e.data); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL to_err_cnt: got %0d expected 1", err_cnt); end
  endtask

  task automatic test_illegal();
    logic got, err; logic [31:0] rd, wd; logic [7:0] sa; int c, nw, nr, nb; resp_t e;
    logic [7:0] bad [2];
    bad[0] = 8'h22; bad[1] = 8'h05;
    do_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{err: 1'b1, data: 32'h0});
      apb_xfer(i[0], bad[i], 32'h12345678, got, rd, err, c, nw, nr, nb, sa, wd);
      e = sb.pop_front();
      checks++; if (nw + nr != 0 || !got || c != 2) begin errors++; $display("FAIL ill_%h: got strobes=%0d ready=%b cycle=%0d expected 0/1/2", bad[i], nw + nr, got, c); end
      checks++; if (err !== e.err || rd !== e.data) begin errors++; $display("FAIL ill_resp_%h: got %b/%h expected %b/%h", bad[i], err, rd, e.err, e.data); end
    end
    checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL ill_err_cnt: got %0d expected 2", err_cnt); end
  endtask

  task automatic test_reset_mid();
    logic got, err; logic [31:0] rd, wd; logic [7:0] sa; int c, nw, nr, nb; resp_t e;
    int late = 0;
    dv_en = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h10;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (read_en !== 1'b1) begin errors++; $display("FAIL mid_in_rd: got read_en=%b expected 1", read_en); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({pready, pslverr, chip_select, write_en, read_en, prdata, addr, write_data, err_cnt} !== 85'h0) begin
      errors++; $display("FAIL mid_reset_zero: got %h expected 0", {pready, pslverr, chip_select, write_en, read_en, prdata, addr, write_data, err_cnt});
    end
    psel = 1'b0; penable = 1'b0; rst_n = 1'b1; dv_en = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (pready) late++; end
    checks++; if (late != 0) begin errors++; $display("FAIL mid_no_ready: got %0d ready cycles expected 0", late); end
    sb.push_back('{err: 1'b0, data: 32'h0});
    apb_xfer(1'b1, 8'h00, 32'hCAFEF00D, got, rd, err, c, nw, nr, nb, sa, wd);
    e = sb.pop_front();
    checks++; if (!got || c != 2 || nw != 1 || wd !== 32'hCAFEF00D || err !== e.err) begin
      errors++; $display("FAIL mid_after_wr: got ready=%b cycle=%0d we=%0d wd=%h err=%b expected 1/2/1/cafef00d/%b", got, c, nw, wd, err, e.err);
    end
  endtask

  task automatic test_saturate();
    logic got, err; logic [31:0] rd, wd; logic [7:0] sa; int c, nw, nr, nb; resp_t e;
    int missed = 0;
    for (int i = 0; i < 300; i++) begin
      sb.push_back('{err: 1'b1, data: 32'h0});
      apb_xfer(1'b1, 8'h40 + 8'(i % 64), 32'h0, got, rd, err, c, nw, nr, nb, sa, wd);
      e = sb.pop_front();
      if (!got || err !== e.err || nw + nr != 0) missed++;
    end
    checks++; if (missed != 0) begin errors++; $display("FAIL sat_resp: got %0d bad responses expected 0", missed); end
    checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_err_cnt: got %h expected ff", err_cnt); end
  endtask

  task automatic test_back_to_back();
    logic got, err; logic [31:0] rd, wd; logic [7:0] sa; int c, nw, nr, nb, t0; resp_t e;
    logic got2; logic [31:0] rd2; logic err2; int nb2;
    t0 = cyc;
    sb.push_back('{err: 1'b0, data: 32'h0});
    sb.push_back('{err: 1'b0, data: 32'hA5A5_0014});
    apb_xfer(1'b1, 8'h14, 32'hA5A5_0014, got, rd, err, c, nw, nr, nb, sa, wd);
    apb_xfer(1'b0, 8'h14, 32'h0, got2, rd2, err2, c, nw, nr, nb2, sa, wd);
    checks++; if (cyc - t0 != 6) begin errors++; $display("FAIL b2b_cycles: got %0d expected 6", cyc - t0); end
    e = sb.pop_front();
    checks++; if (!got || err !== e.err) begin errors++; $display("FAIL b2b_wr: got ready=%b err=%b expected 1/%b", got, err, e.err); end
    e = sb.pop_front();
    checks++; if (!got2 || err2 !== e.err || rd2 !== e.data) begin errors++; $display("FAIL b2b_rd: got %b/%b/%h expected 1/%b/%h", got2, err2, rd2, e.err, e.data); end
    checks++; if (nb + nb2 != 0) begin errors++; $display("FAIL b2b_both_strobes: got %0d expected 0", nb + nb2); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    mem[2] = 32'h1;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_illegal();
    test_reset_mid();
    test_saturate();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
